// File: rtl/win3x3_stream_gen.sv
// Raster-scan 3x3 window generator: two line buffers plus a column bank feed
// interior windows to the median filter. Optional win_cnt output via WIN3X3_WINCNT_EN.
module win3x3_stream_gen #(
  parameter int IMG_W   = 640,
  parameter int IMG_H   = 480,
  parameter int DW      = 8,
  parameter int WIN_GAP = 4
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          frame_start,
  input  logic          pix_in_vld,
  input  logic [DW-1:0] pix_in,
  output logic          pix_in_rdy,
  output logic          win_data_sig,
  output logic [DW-1:0] data_out0,
  output logic [DW-1:0] data_out1,
  output logic [DW-1:0] data_out2,
  output logic [DW-1:0] data_out3,
  output logic [DW-1:0] data_out4,
  output logic [DW-1:0] data_out5,
  output logic [DW-1:0] data_out6,
  output logic [DW-1:0] data_out7,
  output logic [DW-1:0] data_out8,
  output logic          frame_done,
`ifdef WIN3X3_WINCNT_EN
  output logic [$clog2(IMG_W*IMG_H+1)-1:0] win_cnt,
`endif
  output logic [1:0]    state_dbg
);

  localparam int CW  = $clog2(IMG_W);
  localparam int RW  = $clog2(IMG_H);
  localparam int GW  = $clog2(WIN_GAP + 1);
`ifdef WIN3X3_WINCNT_EN
  localparam int WCW = $clog2(IMG_W*IMG_H + 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic [GW-1:0] gap_cnt;
  logic          last_pend;

  logic [DW-1:0] lb1 [IMG_W];
  logic [DW-1:0] lb2 [IMG_W];
  // Only the two older columns are stored; the newest column comes straight
  // from the line buffers and pix_in.
  logic [DW-1:0] l_top, l_mid, l_bot;
  logic [DW-1:0] m_top, m_mid, m_bot;
  logic [DW-1:0] up2, up1;

  logic accept, win_hit, last_col, last_row, gap_end;

  // A pixel transfers when pix_in_vld & pix_in_rdy are both high at a rising
  // edge; rdy is high only in RUN and drops while frame_start is asserted.
  assign accept    = (state == RUN) && pix_in_vld && !frame_start;
  assign last_col  = (col == CW'(IMG_W - 1));
  assign last_row  = (row == RW'(IMG_H - 1));
  assign win_hit   = accept && (row >= RW'(2)) && (col >= CW'(2));
  assign gap_end   = (gap_cnt == GW'(WIN_GAP - 1));
  assign up2       = lb2[col];
  assign up1       = lb1[col];
  assign state_dbg = state;

  always_comb begin
    state_n    = state;
    pix_in_rdy = 1'b0;
    frame_done = 1'b0;
    case (state)
      IDLE: ;
      RUN: begin
        pix_in_rdy = !frame_start;
        if (win_hit) begin
          if (WIN_GAP > 1)            state_n = GAP;
          else if (last_col && last_row) state_n = DONE;
        end
      end
      GAP:  if (gap_end) state_n = last_pend ? DONE : RUN;
      DONE: begin
        frame_done = 1'b1;
        state_n    = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (frame_start) state_n = RUN;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      col          <= '0;
      row          <= '0;
      gap_cnt      <= '0;
      last_pend    <= 1'b0;
      win_data_sig <= 1'b0;
      data_out0    <= '0;
      data_out1    <= '0;
      data_out2    <= '0;
      data_out3    <= '0;
      data_out4    <= '0;
      data_out5    <= '0;
      data_out6    <= '0;
      data_out7    <= '0;
      data_out8    <= '0;
`ifdef WIN3X3_WINCNT_EN
      win_cnt      <= '0;
`endif
    end else begin
      state        <= state_n;
      win_data_sig <= win_hit;
      if (frame_start) begin
        col       <= '0;
        row       <= '0;
        gap_cnt   <= '0;
        last_pend <= 1'b0;
`ifdef WIN3X3_WINCNT_EN
        win_cnt   <= '0;
`endif
      end else begin
        if (accept) begin
          if (last_col) begin
            col <= '0;
            row <= last_row ? '0 : row + RW'(1);
          end else begin
            col <= col + CW'(1);
          end
        end
        if (win_hit)            gap_cnt <= GW'(1);
        else if (state == GAP)  gap_cnt <= gap_cnt + GW'(1);
        if (win_hit && last_col && last_row) last_pend <= 1'b1;
        else if (state == DONE)              last_pend <= 1'b0;
        if (win_hit) begin
          data_out0 <= l_top;
          data_out1 <= m_top;
          data_out2 <= up2;
          data_out3 <= l_mid;
          data_out4 <= m_mid;
          data_out5 <= up1;
          data_out6 <= l_bot;
          data_out7 <= m_bot;
          data_out8 <= pix_in;
`ifdef WIN3X3_WINCNT_EN
          win_cnt   <= win_cnt + WCW'(1);
`endif
        end
      end
    end
  end

  // Line buffers and column bank carry no reset: stale data never reaches a window.
  always_ff @(posedge CLK) begin
    if (accept) begin
      lb2[col] <= up1;
      lb1[col] <= pix_in;
      l_top    <= m_top;
      l_mid    <= m_mid;
      l_bot    <= m_bot;
      m_top    <= up2;
      m_mid    <= up1;
      m_bot    <= pix_in;
    end
  end

endmodule

// File: tb/tb_win3x3_stream_gen.sv
// Bench for win3x3_stream_gen on a 4x3 image: frame-level reference model,
// per-cycle compare process and literal window checks.
module tb_win3x3_stream_gen;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int DW   = 8;
  localparam int G    = 4;
  localparam int NPIX = W * H;
  localparam logic [9*DW-1:0] WIN_A = {8'd1, 8'd2, 8'd3, 8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
  localparam logic [9*DW-1:0] WIN_B = {8'd2, 8'd3, 8'd4, 8'd6, 8'd7, 8'd8, 8'd10, 8'd11, 8'd12};

  logic          clk = 1'b0;
  logic          rst, frame_start, pix_in_vld;
  logic [DW-1:0] pix_in;
  logic          pix_in_rdy, win_data_sig, frame_done;
  logic [DW-1:0] data_out0, data_out1, data_out2, data_out3, data_out4;
  logic [DW-1:0] data_out5, data_out6, data_out7, data_out8;
  logic [1:0]    state_dbg;
`ifdef WIN3X3_WINCNT_EN
  logic [$clog2(W*H+1)-1:0] win_cnt;
`endif

  win3x3_stream_gen #(.IMG_W(W), .IMG_H(H), .DW(DW), .WIN_GAP(G)) dut (
    .CLK(clk), .RST(rst), .frame_start(frame_start),
    .pix_in_vld(pix_in_vld), .pix_in(pix_in), .pix_in_rdy(pix_in_rdy),
    .win_data_sig(win_data_sig),
    .data_out0(data_out0), .data_out1(data_out1), .data_out2(data_out2),
    .data_out3(data_out3), .data_out4(data_out4), .data_out5(data_out5),
    .data_out6(data_out6), .data_out7(data_out7), .data_out8(data_out8),
    .frame_done(frame_done),
`ifdef WIN3X3_WINCNT_EN
    .win_cnt(win_cnt),
`endif
    .state_dbg(state_dbg)
  );

  wire [9*DW-1:0] dout = {data_out0, data_out1, data_out2, data_out3, data_out4,
                          data_out5, data_out6, data_out7, data_out8};

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc++;

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string name, input logic [9*DW-1:0] act, input logic [9*DW-1:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [9*DW-1:0] exp_q[$];
  logic [9*DW-1:0] exp_cur = '0;
  logic [DW-1:0]   img [NPIX];
  bit armed  = 1'b0;
  bit active = 1'b0;
  int k = 0, blk_until = 0, done_at = -1, strobe_at = -1, wc = 0;

  logic [9*DW-1:0] win_log[$];
  int strobe_cyc[$];
  int done_cyc[$];
  int acc_cyc[$];

  always @(negedge clk) begin
    bit rdy_e;
    int r, c;
    logic [9*DW-1:0] w;
    rdy_e = active && (done_at < 0) && (cyc >= blk_until) && !frame_start;
    if (armed) begin
      chk("pix_in_rdy", pix_in_rdy, rdy_e);
      chk("frame_done", frame_done, done_at == cyc);
      chk("win_data_sig", win_data_sig, strobe_at == cyc);
      if (strobe_at == cyc && exp_q.size() > 0) exp_cur = exp_q.pop_front();
      chk("data_out", dout, exp_cur);
`ifdef WIN3X3_WINCNT_EN
      chk("win_cnt", win_cnt, wc);
`endif
    end
    if (win_data_sig === 1'b1) begin
      win_log.push_back(dout);
      strobe_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) done_cyc.push_back(cyc);
    if (pix_in_vld && pix_in_rdy === 1'b1) acc_cyc.push_back(cyc);

    if (rst) begin
      armed = 1'b1; active = 1'b0; k = 0; blk_until = 0;
      done_at = -1; strobe_at = -1; wc = 0;
      exp_q.delete();
      exp_cur = '0;
    end else if (armed) begin
      if (frame_start) begin
        active = 1'b1; k = 0; blk_until = 0; done_at = -1; wc = 0;
      end else if (done_at == cyc) begin
        active = 1'b0; done_at = -1;
      end else if (rdy_e && pix_in_vld) begin
        img[k] = pix_in;
        r = k / W;
        c = k % W;
        if (r >= 2 && c >= 2) begin
          w = {img[(r-2)*W+c-2], img[(r-2)*W+c-1], img[(r-2)*W+c],
               img[(r-1)*W+c-2], img[(r-1)*W+c-1], img[(r-1)*W+c],
               img[r*W+c-2],     img[r*W+c-1],     img[r*W+c]};
          exp_q.push_back(w);
          strobe_at = cyc + 1;
          blk_until = cyc + G;
          wc++;
          if (k == NPIX - 1) done_at = cyc + G;
        end
        k++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  logic [DW-1:0] pix_src [NPIX];

  task automatic clear_logs();
    win_log.delete(); strobe_cyc.delete(); done_cyc.delete(); acc_cyc.delete();
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic idle(input int n, input bit offer);
    pix_in_vld = offer;
    pix_in     = DW'($urandom_range(0, 255));
    repeat (n) begin @(posedge clk); #1; end
    pix_in_vld = 1'b0;
  endtask

  task automatic send_frame(input int pct, input int npix);
    int i = 0;
    int guard = 0;
    while (i < npix && guard < 2000) begin
      pix_in     = pix_src[i];
      pix_in_vld = ($urandom_range(0, 99) < pct);
      @(negedge clk);
      if (pix_in_vld && pix_in_rdy === 1'b1) i++;
      @(posedge clk); #1;
      guard++;
    end
    pix_in_vld = 1'b0;
    nchk++;
    if (i < npix) begin
      nerr++;
      $display("FAIL send_frame: got %0d pixels accepted expected %0d", i, npix);
    end
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int t = 0; t < 20 && !seen; t++) begin
      @(negedge clk);
      seen = (frame_done === 1'b1);
    end
    nchk++;
    if (!seen) begin
      nerr++;
      $display("FAIL wait_done: got no frame_done expected one within 20 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic check_literal(input string tag, input bit full_rate);
    chk({tag, "_nwin"}, win_log.size(), 2);
    if (win_log.size() >= 2) begin
      chk({tag, "_win_a"}, win_log[0], WIN_A);
      chk({tag, "_win_b"}, win_log[1], WIN_B);
      if (full_rate) chk({tag, "_strobe_gap"}, strobe_cyc[1] - strobe_cyc[0], G);
      else           chk({tag, "_strobe_gap_min"}, (strobe_cyc[1] - strobe_cyc[0]) >= G, 1);
    end
    chk({tag, "_ndone"}, done_cyc.size(), 1);
    if (done_cyc.size() >= 1 && acc_cyc.size() >= 2) begin
      chk({tag, "_done_lat"}, done_cyc[0] - acc_cyc[$], G);
      if (full_rate) chk({tag, "_rdy_low"}, acc_cyc[$] - acc_cyc[$-1], G);
    end
`ifdef WIN3X3_WINCNT_EN
    chk({tag, "_win_cnt"}, win_cnt, 2);
`endif
  endtask

  task automatic check_idle_outputs(input string tag);
    @(negedge clk);
    chk({tag, "_rdy"}, pix_in_rdy, 0);
    chk({tag, "_sig"}, win_data_sig, 0);
    chk({tag, "_done"}, frame_done, 0);
    chk({tag, "_dout"}, dout, 0);
    chk({tag, "_state"}, state_dbg, 0);
`ifdef WIN3X3_WINCNT_EN
    chk({tag, "_win_cnt"}, win_cnt, 0);
`endif
    @(posedge clk); #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int np, exp_n;
    bit abort;
    rst = 1'b1; frame_start = 1'b0; pix_in_vld = 1'b0; pix_in = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_idle_outputs("reset");

    for (int i = 0; i < NPIX; i++) pix_src[i] = DW'(i + 1);

    // full-rate frame, also exercising rdy pacing
    clear_logs(); start_frame(); send_frame(100, NPIX); wait_done();
    check_literal("full", 1'b1);
    idle(3, 1'b1);
`ifdef WIN3X3_WINCNT_EN
    start_frame();
    @(negedge clk); chk("win_cnt_clear", win_cnt, 0); @(posedge clk); #1;
    send_frame(100, NPIX); wait_done();
`endif

    // ~50% valid
    clear_logs(); start_frame(); send_frame(50, NPIX); wait_done();
    check_literal("sparse", 1'b0);

    // abort after 6 pixels, then a complete frame
    clear_logs(); start_frame(); send_frame(100, 6);
    start_frame(); send_frame(100, NPIX); wait_done();
    check_literal("abort", 1'b1);

    // reset while in GAP after the first window
    clear_logs(); start_frame(); send_frame(100, NPIX - 1);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    check_idle_outputs("gap_rst");
    idle(6, 1'b1);
    chk("gap_rst_no_done", done_cyc.size(), 0);
    clear_logs(); start_frame(); send_frame(100, NPIX); wait_done();
    check_literal("post_rst", 1'b1);

    // randomized frames, random pixels, optional aborts (incl. during GAP)
    for (int f = 0; f < 30; f++) begin
      for (int i = 0; i < NPIX; i++) pix_src[i] = DW'($urandom_range(0, 255));
      clear_logs();
      exp_n = 2;
      abort = ($urandom_range(0, 2) == 0);
      start_frame();
      if (abort) begin
        np = $urandom_range(1, NPIX - 1);
        send_frame($urandom_range(30, 100), np);
        if (np == NPIX - 1) exp_n = 3;
        start_frame();
      end
      send_frame($urandom_range(30, 100), NPIX);
      wait_done();
      chk("rand_nwin", win_log.size(), exp_n);
      chk("rand_ndone", done_cyc.size(), 1);
      idle($urandom_range(1, 5), 1'(($urandom_range(0, 1))));
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #2000000;
    nerr++;
    $display("FAIL watchdog: got timeout expected bench completion");
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
